// File: rtl/clk_divider_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : clk_divider_pkg                                          |
// | Description : Shared types and constants for the programmable clock    |
// |               divider (FSM state encoding, minimum legal ratio).       |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
package clk_divider_pkg;

    // Divider control states, explicitly encoded.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        RUN_PEND = 2'd2
    } state_t;

    // Smallest divide ratio that yields a usable 50%-ish divided clock.
    localparam int unsigned MIN_DIV = 2;

endpackage : clk_divider_pkg
`default_nettype wire

// File: rtl/clk_divider_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : clk_divider_if                                           |
// | Description : Control/status bundle of the clock divider.              |
// |   master : drives en, div_load, div_value                              |
// |   slave  : drives div_ack, div_err, clk_out, tick, phase, periods      |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
interface clk_divider_if #(
    parameter int WIDTH  = 8,
    parameter int PCNT_W = 16
) ();

    logic              en;
    logic              div_load;
    logic [WIDTH-1:0]  div_value;
    logic              div_ack;
    logic              div_err;
    logic              clk_out;
    logic              tick;
    logic [WIDTH-1:0]  phase;
    logic [PCNT_W-1:0] periods;

    modport master (
        output en, div_load, div_value,
        input  div_ack, div_err, clk_out, tick, phase, periods
    );

    modport slave (
        input  en, div_load, div_value,
        output div_ack, div_err, clk_out, tick, phase, periods
    );

endinterface : clk_divider_if
`default_nettype wire

// File: rtl/clk_divider_phase_counter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : phase_counter                                            |
// | Description : Modulo-N phase counter with wrap flag and synchronous    |
// |               clear.                                                   |
// |   clk, rst_n  : clock, asynchronous active-low reset                   |
// |   i_clr       : force count to 0 on the next edge (wins over i_inc)    |
// |   i_inc       : advance count, wrapping at i_modulus-1                 |
// |   i_modulus   : current ratio N (always >= 2)                          |
// |   o_count     : registered count                                       |
// |   o_count_nxt : value the count takes on the next edge                 |
// |   o_wrap      : count is at its last phase (N-1)                       |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module phase_counter #(
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             i_clr,
    input  wire logic             i_inc,
    input  wire logic [WIDTH-1:0] i_modulus,
    output logic      [WIDTH-1:0] o_count,
    output logic      [WIDTH-1:0] o_count_nxt,
    output logic                  o_wrap
);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nxt;
    logic             w_wrap;

    // ">=" rather than "==" so a stray out-of-range count still wraps.
    always_comb begin
        w_wrap      = (r_count >= (i_modulus - WIDTH'(1)));
        w_count_nxt = r_count;
        if (i_clr) begin
            w_count_nxt = '0;
        end else if (i_inc) begin
            w_count_nxt = w_wrap ? '0 : (r_count + WIDTH'(1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_nxt;
        end
    end

    assign o_count     = r_count;
    assign o_count_nxt = w_count_nxt;
    assign o_wrap      = w_wrap;

endmodule : phase_counter
`default_nettype wire

// File: rtl/clk_divider.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : clk_divider                                              |
// | Description : Programmable glitch-free clock divider with run-time     |
// |               ratio reload (load/ack handshake, boundary-aligned).     |
// |   clk, rst_n : clock, asynchronous active-low reset                    |
// |   bus.en        : run enable (level)                                   |
// |   bus.div_load  : ratio load request, sampled every cycle              |
// |   bus.div_value : requested ratio N                                    |
// |   bus.div_ack   : one-cycle pulse, load accepted                       |
// |   bus.div_err   : one-cycle pulse, load rejected (N < 2)               |
// |   bus.clk_out   : divided clock, low ceil(N/2), high floor(N/2)        |
// |   bus.tick      : high during the last phase of each divided period    |
// |   bus.phase     : current phase                                        |
// |   bus.periods   : completed divided periods, wrapping                  |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module clk_divider
    import clk_divider_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DIV_RESET = 2,
    parameter int PCNT_W    = 16
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    clk_divider_if.slave bus
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WIDTH-1:0]  r_ratio;
    logic [WIDTH-1:0]  w_ratio_nxt;
    logic [WIDTH-1:0]  r_pend;
    logic [WIDTH-1:0]  w_pend_nxt;
    logic              r_clk_out;
    logic              r_tick;
    logic              r_ack;
    logic              r_err;
    logic [PCNT_W-1:0] r_periods;

    logic              w_load_ok;
    logic              w_clr;
    logic              w_inc;
    logic              w_wrap;
    logic [WIDTH-1:0]  w_count;
    logic [WIDTH-1:0]  w_count_nxt;
    logic [WIDTH-1:0]  w_half;
    logic              w_run_nxt;
    logic              w_clk_nxt;
    logic              w_tick_nxt;

    assign w_load_ok = bus.div_load && (bus.div_value >= WIDTH'(MIN_DIV));

    phase_counter #(
        .WIDTH (WIDTH)
    ) u_phase_counter (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clr       (w_clr),
        .i_inc       (w_inc),
        .i_modulus   (r_ratio),
        .o_count     (w_count),
        .o_count_nxt (w_count_nxt),
        .o_wrap      (w_wrap)
    );

    // Next-state, ratio bookkeeping and counter control. The counter always
    // wraps with the ratio currently in force, so a period never changes
    // length part way through.
    always_comb begin
        w_state_nxt = r_state;
        w_ratio_nxt = r_ratio;
        w_pend_nxt  = r_pend;
        w_clr       = 1'b0;
        w_inc       = 1'b0;
        case (r_state)
            IDLE: begin
                w_clr = 1'b1;
                if (w_load_ok) begin
                    w_ratio_nxt = bus.div_value;
                end
                if (bus.en) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (!bus.en) begin
                    w_state_nxt = IDLE;
                    w_clr       = 1'b1;
                    if (w_load_ok) begin
                        w_ratio_nxt = bus.div_value;
                    end
                end else begin
                    w_inc = 1'b1;
                    if (w_load_ok) begin
                        w_pend_nxt  = bus.div_value;
                        w_state_nxt = RUN_PEND;
                    end
                end
            end
            RUN_PEND: begin
                if (!bus.en) begin
                    // Stopping: the newest accepted ratio takes over at once.
                    w_state_nxt = IDLE;
                    w_clr       = 1'b1;
                    w_ratio_nxt = w_load_ok ? bus.div_value : r_pend;
                end else begin
                    w_inc = 1'b1;
                    if (w_wrap) begin
                        w_ratio_nxt = r_pend;
                    end
                    // A load arriving on the wrap edge becomes the next
                    // pending ratio, so we stay in RUN_PEND.
                    if (w_load_ok) begin
                        w_pend_nxt = bus.div_value;
                    end else if (w_wrap) begin
                        w_state_nxt = RUN;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_clr       = 1'b1;
            end
        endcase
    end

    // Output decode from the values that will be registered, so clk_out and
    // tick line up with the phase they describe. Phase 0 always decodes
    // low for N >= 2, which keeps ratio changes free of runt pulses.
    always_comb begin
        w_half     = w_ratio_nxt >> 1;
        w_run_nxt  = (w_state_nxt != IDLE);
        w_clk_nxt  = w_run_nxt && (w_count_nxt >= (w_ratio_nxt - w_half));
        w_tick_nxt = w_run_nxt && (w_count_nxt == (w_ratio_nxt - WIDTH'(1)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_ratio   <= WIDTH'(DIV_RESET);
            r_pend    <= '0;
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
            r_periods <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_ratio   <= w_ratio_nxt;
            r_pend    <= w_pend_nxt;
            r_clk_out <= w_clk_nxt;
            r_tick    <= w_tick_nxt;
            r_ack     <= w_load_ok;
            r_err     <= bus.div_load && !w_load_ok;
            // A period is complete once its tick cycle has ended.
            r_periods <= r_periods + PCNT_W'(r_tick);
        end
    end

    assign bus.div_ack = r_ack;
    assign bus.div_err = r_err;
    assign bus.clk_out = r_clk_out;
    assign bus.tick    = r_tick;
    assign bus.phase   = w_count;
    assign bus.periods = r_periods;

endmodule : clk_divider
`default_nettype wire

// File: tb/tb_clk_divider.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_clk_divider                                           |
// | Description : Directed self-checking bench for clk_divider.            |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_clk_divider;

    localparam int WIDTH     = 8;
    localparam int PCNT_W    = 16;
    localparam int DIV_RESET = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #12 clk = ~clk;

    clk_divider_if #(.WIDTH(WIDTH), .PCNT_W(PCNT_W)) bus ();

    clk_divider #(
        .WIDTH     (WIDTH),
        .DIV_RESET (DIV_RESET),
        .PCNT_W    (PCNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Expected {clk_out, tick, phase} per running cycle.
    typedef struct {
        string      tag;
        logic [9:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Queue the first cnt cycles of a period of ratio n:
    // low for ceil(n/2) cycles, high for floor(n/2), tick on the last one.
    task automatic expect_period(input int n, input int cnt, input string tag);
        for (int p = 0; p < cnt; p++) begin
            exp_t e;
            e.tag = $sformatf("%s.n%0d.p%0d", tag, n, p);
            e.val = {(p >= (n + 1) / 2) ? 1'b1 : 1'b0,
                     (p == n - 1) ? 1'b1 : 1'b0,
                     8'(p)};
            sb.push_back(e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic observe();
        exp_t e;
        if (sb.size() == 0) begin
            n_total++;
            $error("FAIL sb_underflow: observed empty queue expected an entry");
        end else begin
            e = sb.pop_front();
            check(e.tag, 32'({bus.clk_out, bus.tick, bus.phase}), 32'(e.val));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.en        = 1'b0;
        bus.div_load  = 1'b0;
        bus.div_value = '0;

        // Reset state
        step();
        step();
        check("rst.outs", 32'({bus.clk_out, bus.tick, bus.div_ack, bus.div_err}), 0);
        check("rst.phase", 32'(bus.phase), 0);
        check("rst.periods", 32'(bus.periods), 0);
        rst_n = 1'b1;

        // N=2 from reset: 5 periods over 10 running cycles
        bus.en = 1'b1;
        for (int i = 0; i < 5; i++) expect_period(2, 2, "t1");
        repeat (10) begin step(); observe(); end
        bus.en = 1'b0;
        step();
        check("t1.periods", 32'(bus.periods), 5);
        check("t1.idle", 32'({bus.clk_out, bus.tick, bus.phase}), 0);

        // Load 5 while idle, then run
        bus.div_load  = 1'b1;
        bus.div_value = 8'd5;
        step();
        check("t2.ack", 32'({bus.div_ack, bus.div_err}), 32'b10);
        bus.div_load = 1'b0;
        bus.en       = 1'b1;
        expect_period(5, 5, "t2");
        step(); observe();
        check("t2.ack_clr", 32'({bus.div_ack, bus.div_err}), 0);
        repeat (4) begin step(); observe(); end

        // en falls together with a load of 4: ratio applied at once
        bus.en        = 1'b0;
        bus.div_load  = 1'b1;
        bus.div_value = 8'd4;
        step();
        check("t3.idle", 32'({bus.clk_out, bus.tick, bus.phase}), 0);
        check("t3.ack", 32'({bus.div_ack, bus.div_err}), 32'b10);
        bus.div_load = 1'b0;
        bus.en       = 1'b1;

        // Running at N=4, load 6 at phase 1
        expect_period(4, 4, "t3");
        step(); observe();
        step(); observe();
        bus.div_load  = 1'b1;
        bus.div_value = 8'd6;
        expect_period(6, 6, "t3");
        step(); observe();
        check("t3.ack6", 32'({bus.div_ack, bus.div_err}), 32'b10);
        bus.div_load = 1'b0;
        step(); observe();
        check("t3.ack6_clr", 32'({bus.div_ack, bus.div_err}), 0);
        repeat (6) begin step(); observe(); end

        // Illegal loads 1 then 0: error pulses, period stays 6
        bus.div_load  = 1'b1;
        bus.div_value = 8'd1;
        expect_period(6, 6, "t4");
        step(); observe();
        check("t4.err1", 32'({bus.div_ack, bus.div_err}), 32'b01);
        bus.div_value = 8'd0;
        step(); observe();
        check("t4.err0", 32'({bus.div_ack, bus.div_err}), 32'b01);
        bus.div_load = 1'b0;
        step(); observe();
        check("t4.err_clr", 32'({bus.div_ack, bus.div_err}), 0);
        repeat (3) begin step(); observe(); end

        // Load 4 on the wrap edge: one more period of 6, then 4
        bus.div_load  = 1'b1;
        bus.div_value = 8'd4;
        expect_period(6, 6, "t5");
        expect_period(4, 3, "t5");
        step(); observe();
        check("t5.ack4", 32'({bus.div_ack, bus.div_err}), 32'b10);
        bus.div_load = 1'b0;
        repeat (5) begin step(); observe(); end
        step(); observe();
        // Pending 8, then drop en at phase 2
        bus.div_load  = 1'b1;
        bus.div_value = 8'd8;
        step(); observe();
        check("t5.ack8", 32'({bus.div_ack, bus.div_err}), 32'b10);
        bus.div_load = 1'b0;
        step(); observe();
        bus.en = 1'b0;
        step();
        check("t5.idle", 32'({bus.clk_out, bus.tick, bus.phase}), 0);
        bus.en = 1'b1;
        expect_period(8, 8, "t5");
        repeat (8) begin step(); observe(); end

        // Async reset mid-period with a pending ratio and a live ack
        expect_period(8, 2, "t6");
        step(); observe();
        bus.div_load  = 1'b1;
        bus.div_value = 8'd3;
        step(); observe();
        check("t6.ack3", 32'({bus.div_ack, bus.div_err}), 32'b10);
        bus.div_value = 8'd7;
        #5;
        rst_n = 1'b0;
        #1;
        check("t6.rst_outs", 32'({bus.clk_out, bus.tick, bus.div_ack, bus.div_err, bus.phase}), 0);
        check("t6.rst_periods", 32'(bus.periods), 0);
        bus.div_load = 1'b0;
        bus.en       = 1'b0;
        step();
        rst_n  = 1'b1;
        bus.en = 1'b1;
        expect_period(DIV_RESET, DIV_RESET, "t6");
        expect_period(DIV_RESET, 1, "t6");
        step(); observe();
        check("t6.periods0", 32'(bus.periods), 0);
        step(); observe();
        step(); observe();
        check("t6.periods1", 32'(bus.periods), 1);

        check("sb.empty", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_clk_divider
`default_nettype wire
